// File: rtl/spec_free_list_if.sv
// Rename-side bundle for the speculative physical-register free list.
// Allocate requests, tags handed out, commit releases and status.
interface spec_free_list_if #(
  parameter int TAG_W = 7,
  parameter int PTR_W = 5
);

  logic             flush_i;
  logic             allocate_i;
  logic [3:0]       reqVector_i;
  logic [TAG_W-1:0] freeReg0_o;
  logic [TAG_W-1:0] freeReg1_o;
  logic [TAG_W-1:0] freeReg2_o;
  logic [TAG_W-1:0] freeReg3_o;
  logic             freeListEmpty_o;
  logic [3:0]       commitVector_i;
  logic [TAG_W-1:0] commitReg0_i;
  logic [TAG_W-1:0] commitReg1_i;
  logic [TAG_W-1:0] commitReg2_i;
  logic [TAG_W-1:0] commitReg3_i;
  logic [PTR_W:0]   freeCount_o;

  modport master (
    output flush_i, allocate_i, reqVector_i,
    output commitVector_i,
    output commitReg0_i, commitReg1_i,
    output commitReg2_i, commitReg3_i,
    input  freeReg0_o, freeReg1_o,
    input  freeReg2_o, freeReg3_o,
    input  freeListEmpty_o, freeCount_o
  );

  modport slave (
    input  flush_i, allocate_i, reqVector_i,
    input  commitVector_i,
    input  commitReg0_i, commitReg1_i,
    input  commitReg2_i, commitReg3_i,
    output freeReg0_o, freeReg1_o,
    output freeReg2_o, freeReg3_o,
    output freeListEmpty_o, freeCount_o
  );

endinterface

// File: rtl/spec_free_list.sv
// Physical register free list: 4-wide allocate, 4-wide release.
// Mispredict flush rewinds allocation to the last commit point.
module spec_free_list #(
  parameter int PHY_REGS  = 96,
  parameter int ARCH_REGS = 64,
  parameter int TAG_W     = 7
) (
  input logic clk,
  input logic reset,
  spec_free_list_if.slave fl
);

  localparam int FL_SIZE = PHY_REGS - ARCH_REGS;
  localparam int PTR_W   = $clog2(FL_SIZE);

  typedef logic [PTR_W:0]   ptr_t;
  typedef logic [PTR_W-1:0] idx_t;
  typedef logic [TAG_W-1:0] tag_t;

  tag_t ring [FL_SIZE];
  ptr_t head;
  ptr_t commitHead;
  ptr_t tail;
  ptr_t freeCount;

  tag_t       commitReg [4];
  idx_t       rdIdx [4];
  idx_t       wrIdx [4];
  logic [2:0] popN;
  logic [2:0] pushN;
  logic       doPop;

  function automatic logic [2:0] lowCount(
    input logic [3:0] v,
    input int         n
  );
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < 4; i++)
      if (i < n) c = c + {2'b00, v[i]};
    return c;
  endfunction

  // Lane slots are prefix-count offsets from head (read) and tail (write).
  always_comb begin
    commitReg[0] = fl.commitReg0_i;
    commitReg[1] = fl.commitReg1_i;
    commitReg[2] = fl.commitReg2_i;
    commitReg[3] = fl.commitReg3_i;
    for (int k = 0; k < 4; k++) begin
      rdIdx[k] = head[PTR_W-1:0] +
                 idx_t'(lowCount(fl.reqVector_i, k));
      wrIdx[k] = tail[PTR_W-1:0] +
                 idx_t'(lowCount(fl.commitVector_i, k));
    end
    popN  = lowCount(fl.reqVector_i, 4);
    pushN = lowCount(fl.commitVector_i, 4);
    doPop = fl.allocate_i &&
            !fl.freeListEmpty_o &&
            !fl.flush_i;
  end

  assign fl.freeReg0_o      = ring[rdIdx[0]];
  assign fl.freeReg1_o      = ring[rdIdx[1]];
  assign fl.freeReg2_o      = ring[rdIdx[2]];
  assign fl.freeReg3_o      = ring[rdIdx[3]];
  assign fl.freeCount_o     = freeCount;
  assign fl.freeListEmpty_o = freeCount < ptr_t'(4);

  // Ring writes and pointer moves; a flush rewinds head past this cycle's commits.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FL_SIZE; i++)
        ring[i] <= tag_t'(ARCH_REGS + i);
      head       <= '0;
      commitHead <= '0;
      tail       <= {1'b1, idx_t'(0)};
      freeCount  <= ptr_t'(FL_SIZE);
    end else begin
      for (int k = 0; k < 4; k++)
        if (fl.commitVector_i[k])
          ring[wrIdx[k]] <= commitReg[k];
      tail       <= tail + ptr_t'(pushN);
      commitHead <= commitHead + ptr_t'(pushN);
      if (fl.flush_i) begin
        head      <= commitHead + ptr_t'(pushN);
        freeCount <= ptr_t'(FL_SIZE);
      end else begin
        head      <= head +
                     (doPop ? ptr_t'(popN) : '0);
        freeCount <= freeCount + ptr_t'(pushN) -
                     (doPop ? ptr_t'(popN) : '0);
      end
    end
  end

  // Releases never overfill the ring; committed window always spans it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (int'(freeCount) + int'(pushN) <=
              FL_SIZE + (doPop ? int'(popN) : 0));
      assert (ptr_t'(tail - commitHead) ==
              ptr_t'(FL_SIZE));
    end
  end

endmodule

// File: tb/tb_spec_free_list.sv
// Randomized scoreboard bench for spec_free_list.
// Reference model keeps free/speculative/live tags as plain queues.
module tb_spec_free_list;

  localparam int FL = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spec_free_list_if #(.TAG_W(7), .PTR_W(5)) bus ();

  spec_free_list dut (
    .clk   (clk),
    .reset (reset),
    .fl    (bus)
  );

  typedef struct {
    int               step;
    logic [3:0]       mask;
    logic [3:0]       issue;
    logic [3:0][6:0]  tag;
    int               cnt;
    logic             empty;
  } exp_t;

  exp_t expQ[$];
  int   freeQ[$];
  int   specQ[$];
  int   live[$];
  int   tailCnt;
  int   stepNo = 0;
  int   errors = 0;
  int   checks = 0;
  logic [5:0] invDiff;

  function automatic int pc(logic [3:0] v, int n);
    int c = 0;
    for (int i = 0; i < n; i++) c += int'(v[i]);
    return c;
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic modelReset();
    freeQ.delete();
    specQ.delete();
    live.delete();
    for (int i = 0; i < FL; i++) freeQ.push_back(64 + i);
    for (int i = 0; i < 64; i++) live.push_back(i);
    tailCnt = FL;
  endtask

  task automatic liveRemove(int t);
    for (int i = 0; i < live.size(); i++)
      if (live[i] == t) begin
        live.delete(i);
        return;
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one cycle of stimulus, queue its expected outputs, advance model.
  task automatic drive(bit alloc, logic [3:0] req, bit fl,
                       logic [3:0] cv, logic [3:0][6:0] ct);
    exp_t e;
    int   off;
    bit   pop;
    bus.allocate_i     = alloc;
    bus.reqVector_i    = req;
    bus.flush_i        = fl;
    bus.commitVector_i = cv;
    bus.commitReg0_i   = ct[0];
    bus.commitReg1_i   = ct[1];
    bus.commitReg2_i   = ct[2];
    bus.commitReg3_i   = ct[3];
    e.step  = stepNo++;
    e.mask  = '0;
    e.issue = '0;
    e.tag   = '0;
    e.cnt   = freeQ.size();
    e.empty = freeQ.size() < 4;
    pop = alloc && !fl && !e.empty;
    for (int k = 0; k < 4; k++) begin
      off = pc(req, k);
      if (req[k] && off < freeQ.size()) begin
        e.mask[k]  = 1'b1;
        e.tag[k]   = 7'(freeQ[off]);
        e.issue[k] = pop;
      end
    end
    expQ.push_back(e);
    if (pop)
      for (int n = 0; n < pc(req, 4); n++)
        specQ.push_back(freeQ.pop_front());
    for (int k = 0; k < 4; k++)
      if (cv[k]) begin
        liveRemove(int'(ct[k]));
        live.push_back(specQ.pop_front());
        freeQ.push_back(int'(ct[k]));
        tailCnt++;
      end
    if (fl)
      while (specQ.size() > 0)
        freeQ.push_front(specQ.pop_back());
  endtask

  task automatic doReset();
    reset              = 1'b1;
    bus.flush_i        = 1'($urandom);
    bus.allocate_i     = 1'b1;
    bus.reqVector_i    = 4'($urandom);
    bus.commitVector_i = 4'($urandom);
    bus.commitReg0_i   = 7'($urandom);
    bus.commitReg1_i   = 7'($urandom);
    bus.commitReg2_i   = 7'($urandom);
    bus.commitReg3_i   = 7'($urandom);
    tick();
    reset = 1'b0;
    modelReset();
  endtask

  // Monitor: pop one expectation per cycle and compare DUT outputs.
  always @(negedge clk) begin
    exp_t e;
    logic [3:0][6:0] act;
    if (!reset) begin
      invDiff = dut.tail - dut.commitHead;
      checks++;
      if (invDiff != 6'd32) begin
        errors++;
        $display("FAIL invariant: tail-commitHead=%0d expected 32",
                 invDiff);
      end
    end
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      act = {bus.freeReg3_o, bus.freeReg2_o,
             bus.freeReg1_o, bus.freeReg0_o};
      for (int k = 0; k < 4; k++) begin
        if (e.mask[k]) begin
          checks++;
          if (act[k] != e.tag[k]) begin
            errors++;
            $display("FAIL lane%0d step %0d: got %0d expected %0d",
                     k, e.step, act[k], e.tag[k]);
          end
        end
        if (e.issue[k]) begin
          checks++;
          for (int i = 0; i < live.size(); i++)
            if (live[i] == int'(act[k])) begin
              errors++;
              $display("FAIL live_dup lane%0d step %0d: got %0d expected not live",
                       k, e.step, act[k]);
            end
        end
      end
      checks++;
      if (int'(bus.freeCount_o) != e.cnt) begin
        errors++;
        $display("FAIL count step %0d: got %0d expected %0d",
                 e.step, bus.freeCount_o, e.cnt);
      end
      checks++;
      if (bus.freeListEmpty_o != e.empty) begin
        errors++;
        $display("FAIL empty step %0d: got %0d expected %0d",
                 e.step, bus.freeListEmpty_o, e.empty);
      end
    end
  end

  initial begin
    logic [3:0][6:0] ct;
    logic [3:0]      rq;
    logic [3:0]      cv;
    bit              a;
    bit              f;
    int              pool[$];
    int              j;

    reset = 1'b1;
    doReset();

    // Mixed lanes straight out of reset
    drive(1'b1, 4'b1011, 1'b0, 4'b0000, '0);
    #1;
    chk("r30_lane0", int'(bus.freeReg0_o), 64);
    chk("r30_lane1", int'(bus.freeReg1_o), 65);
    chk("r30_lane3", int'(bus.freeReg3_o), 66);
    tick();
    drive(1'b0, 4'b1111, 1'b0, 4'b0000, '0);
    #1;
    chk("r30_count", int'(bus.freeCount_o), 29);
    chk("r30_next0", int'(bus.freeReg0_o), 67);
    tick();

    // Drain to empty, then a further allocate must not pop
    doReset();
    repeat (8) begin
      drive(1'b1, 4'b1111, 1'b0, 4'b0000, '0);
      tick();
    end
    chk("r31_count", int'(bus.freeCount_o), 0);
    chk("r31_empty", int'(bus.freeListEmpty_o), 1);
    drive(1'b1, 4'b1111, 1'b0, 4'b0000, '0);
    tick();
    chk("r31_count9", int'(bus.freeCount_o), 0);
    chk("r31_head9", int'(dut.head), 32);

    // Pop at count 4 with a simultaneous release of two tags
    doReset();
    repeat (7) begin
      drive(1'b1, 4'b1111, 1'b0, 4'b0000, '0);
      tick();
    end
    chk("r32_count4", int'(bus.freeCount_o), 4);
    ct = '0;
    ct[0] = 7'd10;
    ct[2] = 7'd20;
    drive(1'b1, 4'b1111, 1'b0, 4'b0101, ct);
    tick();
    chk("r32_count", int'(bus.freeCount_o), 2);
    chk("r32_empty", int'(bus.freeListEmpty_o), 1);
    chk("r32_ringA", int'(dut.ring[5'(tailCnt - 2)]), 10);
    chk("r32_ringB", int'(dut.ring[5'(tailCnt - 1)]), 20);

    // Allocate 12, commit 4, flush back to the commit point
    doReset();
    repeat (3) begin
      drive(1'b1, 4'b1111, 1'b0, 4'b0000, '0);
      tick();
    end
    ct = {7'd4, 7'd3, 7'd2, 7'd1};
    drive(1'b0, 4'b0000, 1'b0, 4'b1111, ct);
    tick();
    drive(1'b0, 4'b0000, 1'b1, 4'b0000, '0);
    tick();
    chk("r33_count", int'(bus.freeCount_o), 32);
    chk("r33_head", int'(dut.head), 4);
    chk("r33_chead", int'(dut.commitHead), 4);
    chk("r33_lane0", int'(bus.freeReg0_o), 68);

    // Lanes straddling the end of the ring
    doReset();
    repeat (7) begin
      drive(1'b1, 4'b1111, 1'b0, 4'b0000, '0);
      tick();
    end
    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < 4; k++) ct[k] = 7'(4 * i + k);
      drive(1'b0, 4'b0000, 1'b0, 4'b1111, ct);
      tick();
    end
    drive(1'b1, 4'b0011, 1'b0, 4'b0000, '0);
    tick();
    drive(1'b1, 4'b1111, 1'b0, 4'b0000, '0);
    #1;
    chk("r34_lane0", int'(bus.freeReg0_o), 94);
    chk("r34_lane1", int'(bus.freeReg1_o), 95);
    chk("r34_lane2", int'(bus.freeReg2_o), 0);
    chk("r34_lane3", int'(bus.freeReg3_o), 1);
    tick();

    // Mid-operation reset restores the initial state in one cycle
    doReset();
    drive(1'b0, 4'b1111, 1'b0, 4'b0000, '0);
    #1;
    chk("r29_count", int'(bus.freeCount_o), 32);
    chk("r29_lane0", int'(bus.freeReg0_o), 64);
    chk("r29_lane3", int'(bus.freeReg3_o), 67);
    chk("r29_empty", int'(bus.freeListEmpty_o), 0);
    tick();

    // Random allocate / release / flush traffic
    for (int c = 0; c < 10000; c++) begin
      a  = ($urandom % 10) < 7;
      f  = ($urandom % 40) == 0;
      rq = 4'($urandom);
      cv = ($urandom % 2) == 0 ? 4'($urandom) : 4'b0000;
      for (int k = 3; k >= 0; k--)
        if (pc(cv, 4) > specQ.size()) cv[k] = 1'b0;
      pool = live;
      for (int k = 0; k < 4; k++) begin
        if (cv[k]) begin
          j = $urandom_range(0, pool.size() - 1);
          ct[k] = 7'(pool[j]);
          pool.delete(j);
        end else begin
          ct[k] = 7'($urandom);
        end
      end
      drive(a, rq, f, cv, ct);
      tick();
    end

    bus.allocate_i     = 1'b0;
    bus.commitVector_i = 4'b0000;
    bus.flush_i        = 1'b0;
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spec_free_list.md
SPEC_FREE_LIST -- requirements
Module: spec_free_list

Interface
REQ-001 Parameter PHY_REGS, default 96, total physical registers.
REQ-002 Parameter ARCH_REGS, default 64, architectural registers; FL_SIZE = PHY_REGS-ARCH_REGS (default 32, power of two).
REQ-003 Parameter TAG_W, default 7, physical tag width; PTR_W = log2(FL_SIZE).
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 flush_i  in  1  control mispredict recovery; discards all speculative allocations.
REQ-007 allocate_i  in  1  rename bundle present (instruction buffer ready and no back-end stall).
REQ-008 reqVector_i  in  4  per-lane destination-valid for the 4-wide rename bundle.
REQ-009 freeReg0_o..freeReg3_o  out  TAG_W each  tag assigned to lane k (valid only where reqVector_i[k]=1).
REQ-010 freeListEmpty_o  out  1  fewer than 4 free tags; rename stalls.
REQ-011 commitVector_i  in  4  per-lane commit of instruction with destination.
REQ-012 commitReg0_i..commitReg3_i  in  TAG_W each  previous mapping released by committing lane k.
REQ-013 freeCount_o  out  PTR_W+1  registered number of free tags.

Function
REQ-014 Storage: FL_SIZE x TAG_W ring; pointers head, commitHead, tail each PTR_W+1 bits (wrap bit + index), arithmetic modulo 2*FL_SIZE.
REQ-015 Combinational outputs: freeRegk_o = ring[(head + popcount(reqVector_i[k-1:0])) mod FL_SIZE]; lane 0 reads ring[head].
REQ-016 freeListEmpty_o = (freeCount_o < 4), combinational from registered count.
REQ-017 Pop: when allocate_i=1 and freeListEmpty_o=0, head advances by popcount(reqVector_i); when freeListEmpty_o=1, no pop regardless of allocate_i.
REQ-018 Push: each set bit of commitVector_i writes commitRegk_i to ring[(tail + popcount(commitVector_i[k-1:0])) mod FL_SIZE]; tail and commitHead each advance by popcount(commitVector_i).
REQ-019 Count: freeCount next = freeCount + pushes - pops, same cycle; simultaneous push and pop legal; result never exceeds FL_SIZE.
REQ-020 A pop and a push in the same cycle read pre-update ring contents; a just-pushed tag is poppable no earlier than the next cycle.
REQ-021 Invariant: tail - commitHead == FL_SIZE at all times (ring full of committed-free plus speculative tags).
REQ-022 Flush: head <= commitHead after applying same-cycle commit; freeCount <= FL_SIZE; same-cycle pop suppressed; same-cycle push performed.
REQ-023 Flush has priority over allocate_i; reset has priority over flush_i.
REQ-024 Empty boundary: pops with freeCount exactly 4 and 4 requests leave freeCount=0 and assert freeListEmpty_o next cycle.
REQ-025 Wrap-around: pointer index wraps modulo FL_SIZE; lane addresses crossing the end of the ring wrap correctly.
REQ-026 Illegal: commit pushes that would make freeCount > FL_SIZE do not occur; assertion only, no correction logic.

Reset
REQ-027 On reset: ring[i] = ARCH_REGS + i for i in 0..FL_SIZE-1; head=0; commitHead=0; tail={1,0} (full); freeCount_o=FL_SIZE.
REQ-028 During reset all inputs ignored; freeReg0_o..3_o = 64,65,66,67 (defaults) and freeListEmpty_o=0 on the first cycle after reset.
REQ-029 Reset asserted mid-operation restores REQ-027 state in one cycle, discarding outstanding pops and pushes.

Verification
REQ-030 Reset, allocate_i=1, reqVector_i=4'b1011 -> freeReg0/1/3_o=64,65,66; next cycle freeCount_o=29, freeReg0_o=67.
REQ-031 Eight cycles allocate 4'b1111, no commit -> freeCount_o=0, freeListEmpty_o=1; ninth allocate -> head and count unchanged.
REQ-032 freeCount_o=4, same cycle allocate 4'b1111 and commit 4'b0101 with tags 10,20 -> freeCount_o=2; next cycle ring[tail-2..tail-1]=10,20.
REQ-033 Allocate 12 tags, commit 4 (tags 1,2,3,4), then flush_i -> freeCount_o=32, head=commitHead, freeReg0_o = 68 (first uncommitted speculative tag).
REQ-034 Run allocate/commit past FL_SIZE so head straddles index 31->0 with 4'b1111 -> lanes receive ring[30],ring[31],ring[0],ring[1].
REQ-035 Random allocate/commit/flush for 10k cycles -> invariant REQ-021 holds and no tag is ever issued twice while live.
